// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath constants.
package lc3_pkg;

    localparam int LC3_WORD_W = 16;

endpackage : lc3_pkg

// File: rtl/tribuf.sv
// Tri-state bus driver: drives data_in onto a shared bus net when enabled, else releases it to 'z.
// Latency: 0 cycles (REGISTERED=0) or 1 cycle after rising clk (REGISTERED=1).
// Backpressure: none; the bus is an unconditional net, contention resolved by the net type.
module tribuf
    import lc3_pkg::*;
#(
    parameter int WIDTH      = LC3_WORD_W,
    parameter bit REGISTERED = 1'b0
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             enable,
    output tri   [WIDTH-1:0] data_out,
    input  logic             clk,
    input  logic             rst_n
);

    // An unknown enable falls into the else branch, so X/Z never turns the driver on.
    logic drive_en;

    always_comb begin
        drive_en = 1'b0;
        if (enable) begin
            drive_en = 1'b1;
        end
    end

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] data_q;
            logic             en_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                    en_q   <= 1'b0;
                end else begin
                    data_q <= data_in;
                    en_q   <= drive_en;
                end
            end

            assign data_out = en_q ? data_q : {WIDTH{1'bz}};
        end else begin : g_comb
            // Clock and reset may float in this build.
            wire unused_clk_rst = &{1'b0, clk, rst_n};

            assign data_out = drive_en ? data_in : {WIDTH{1'bz}};
        end
    endgenerate

endmodule : tribuf

// File: tb/tb_tribuf.sv
// Directed bench for tribuf: each build drives a pulled-up and a pulled-down bus, so a released bus reads all-ones on one and all-zeros on the other.
module tb_tribuf;

    logic        clk;
    logic        rst_n;

    logic [15:0] c_data;
    logic        c_en;
    logic [15:0] r_data;
    logic        r_en;
    logic [7:0]  w_data;
    logic        w_en;

    tri1 [15:0]  c_bus_up;
    tri0 [15:0]  c_bus_dn;
    tri1 [15:0]  r_bus_up;
    tri0 [15:0]  r_bus_dn;
    tri1 [7:0]   w_bus_up;
    tri0 [7:0]   w_bus_dn;

    int n_checks;
    int n_errors;

    tribuf #(.WIDTH(16), .REGISTERED(1'b0)) u_comb_up (
        .data_in(c_data), .enable(c_en), .data_out(c_bus_up), .clk(clk), .rst_n(rst_n));
    tribuf #(.WIDTH(16), .REGISTERED(1'b0)) u_comb_dn (
        .data_in(c_data), .enable(c_en), .data_out(c_bus_dn), .clk(clk), .rst_n(rst_n));
    tribuf #(.WIDTH(16), .REGISTERED(1'b1)) u_reg_up (
        .data_in(r_data), .enable(r_en), .data_out(r_bus_up), .clk(clk), .rst_n(rst_n));
    tribuf #(.WIDTH(16), .REGISTERED(1'b1)) u_reg_dn (
        .data_in(r_data), .enable(r_en), .data_out(r_bus_dn), .clk(clk), .rst_n(rst_n));
    tribuf #(.WIDTH(8), .REGISTERED(1'b0)) u_w8_up (
        .data_in(w_data), .enable(w_en), .data_out(w_bus_up), .clk(clk), .rst_n(rst_n));
    tribuf #(.WIDTH(8), .REGISTERED(1'b0)) u_w8_dn (
        .data_in(w_data), .enable(w_en), .data_out(w_bus_dn), .clk(clk), .rst_n(rst_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Released: pulled-up copy reads all ones, pulled-down copy reads all zeros.
    task automatic check_bus(input string tag, input logic [15:0] up, input logic [15:0] dn,
                             input logic driven, input logic [15:0] val, input logic [15:0] ones);
        if (driven) begin
            check({tag, "_up"}, up, val);
            check({tag, "_dn"}, dn, val);
        end else begin
            check({tag, "_zup"}, up, ones);
            check({tag, "_zdn"}, dn, 16'h0000);
        end
    endtask

    task automatic comb_step(input logic en, input logic [15:0] d, input string tag,
                             input logic driven, input logic [15:0] val);
        c_en   = en;
        c_data = d;
        #1;
        check_bus(tag, c_bus_up, c_bus_dn, driven, val, 16'hFFFF);
    endtask

    task automatic w8_step(input logic en, input logic [7:0] d, input string tag,
                           input logic driven, input logic [15:0] val);
        w_en   = en;
        w_data = d;
        #1;
        check_bus(tag, {8'h00, w_bus_up}, {8'h00, w_bus_dn}, driven, val, 16'h00FF);
    endtask

    task automatic reg_chk(input string tag, input logic driven, input logic [15:0] val);
        check_bus(tag, r_bus_up, r_bus_dn, driven, val, 16'hFFFF);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        c_en     = 1'b0;
        c_data   = 16'h0000;
        r_en     = 1'b1;
        r_data   = 16'h3A5C;
        w_en     = 1'b0;
        w_data   = 8'h00;

        // Combinational build
        comb_step(1'b0, 16'h0000, "comb_rel_zero", 1'b0, 16'h0000);
        comb_step(1'b1, 16'h0000, "comb_drv_zero", 1'b1, 16'h0000);
        comb_step(1'b0, 16'hFFFF, "comb_rel_ones", 1'b0, 16'h0000);
        comb_step(1'b1, 16'hFFFF, "comb_drv_ones", 1'b1, 16'hFFFF);
        comb_step(1'b1, 16'h5A3C, "comb_drv_mix",  1'b1, 16'h5A3C);
        comb_step(1'bx, 16'h5A3C, "comb_en_x",     1'b0, 16'h0000);
        comb_step(1'b1, 16'hC3A5, "comb_together", 1'b1, 16'hC3A5);
        comb_step(1'b0, 16'hC3A5, "comb_rel_last", 1'b0, 16'h0000);

        // Width 8 build
        w8_step(1'b1, 8'hA5, "w8_drv", 1'b1, 16'h00A5);
        w8_step(1'b0, 8'hA5, "w8_rel", 1'b0, 16'h0000);

        // Registered build: held in reset with enable high, bus must stay released
        #1;
        reg_chk("reg_in_reset", 1'b0, 16'h0000);
        @(posedge clk); #1;
        reg_chk("reg_reset_edge", 1'b0, 16'h0000);

        @(negedge clk);
        r_en  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        reg_chk("reg_first_idle", 1'b0, 16'h0000);

        // Mid-cycle change appears only after the next rising edge
        @(negedge clk);
        r_en   = 1'b1;
        r_data = 16'h3A5C;
        #1;
        reg_chk("reg_before_edge", 1'b0, 16'h0000);
        @(posedge clk); #1;
        reg_chk("reg_after_edge", 1'b1, 16'h3A5C);

        @(negedge clk);
        r_data = 16'h1234;
        #1;
        reg_chk("reg_hold_old", 1'b1, 16'h3A5C);
        @(posedge clk); #1;
        reg_chk("reg_drv_1234", 1'b1, 16'h1234);

        // Asynchronous reset mid-drive
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reg_chk("reg_async_rst", 1'b0, 16'h0000);
        @(posedge clk); #1;
        reg_chk("reg_rst_hold", 1'b0, 16'h0000);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        reg_chk("reg_post_rst_wait", 1'b0, 16'h0000);
        @(posedge clk); #1;
        reg_chk("reg_post_rst_drv", 1'b1, 16'h1234);

        // Enable and data change together, then release
        @(negedge clk);
        r_en   = 1'b0;
        r_data = 16'hFFFF;
        @(posedge clk); #1;
        reg_chk("reg_release", 1'b0, 16'h0000);

        @(negedge clk);
        r_en   = 1'b1;
        r_data = 16'h0000;
        @(posedge clk); #1;
        reg_chk("reg_drv_zero", 1'b1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_tribuf
